ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 38 +++
 rtl/ram_arbiter_mem_align.sv | 81 ++++++++
 rtl/ram_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
//   Shared definitions for the two-port RAM arbiter:
//   - state_e      : arbiter FSM encoding (IDLE / ACCESS / CAPTURE)
//   - SIZE_*       : data-port access size codes
//   - MASK_NONE    : active-low byte-enable value meaning "no lane written"
//   - is_misaligned: alignment rule shared by the steering logic
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_BAD  = 2'd3;

  localparam logic [3:0] MASK_NONE = 4'hF;

  // A half must sit on an even byte, a word on a multiple of four;
  // the reserved size code is always treated as a bad access.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = |addr_lo;
      SIZE_BAD:  bad = 1'b1;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ram_arbiter_mem_align.sv
// mem_align
//   Purely combinational lane logic for the data port.
//   Store side (driven from the live request operands):
//     st_size_i, st_addr_i  : access size and low address bits
//     st_wdata_i            : raw store data (low bytes significant)
//     st_wdata_o            : data replicated into every lane it may occupy
//     st_mask_n_o           : active-low byte enables, all ones when misaligned
//     st_misaligned_o       : access is misaligned or uses the reserved size
//   Load side (driven from the operands latched at grant):
//     ld_size_i, ld_addr_i  : access size and low address bits
//     ld_signed_i           : sign-extend instead of zero-extend
//     ld_raw_i              : full RAM word
//     ld_data_o             : selected lane, extended to 32 bits
module mem_align
  import ram_arbiter_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_wdata_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_mask_n_o,
  output logic        st_misaligned_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_i,
  input  logic        ld_signed_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] ld_data_o
);

  logic [3:0]  lane_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign st_misaligned_o = is_misaligned(st_size_i, st_addr_i);

  // Replicating narrow data means the RAM only needs the byte enables to
  // pick the destination lane; no shifter on the write path.
  always_comb begin
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      SIZE_BYTE: st_wdata_o = {4{st_wdata_i[7:0]}};
      SIZE_HALF: st_wdata_o = {2{st_wdata_i[15:0]}};
      default:   st_wdata_o = st_wdata_i;
    endcase
  end

  // One comparator per byte lane: does this access touch lane gi?
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_hit[gi] = (st_size_i == SIZE_BYTE) ? (st_addr_i == LANE) :
                            (st_size_i == SIZE_HALF) ? (st_addr_i[1] == LANE[1]) :
                            (st_size_i == SIZE_WORD);
    end
  endgenerate

  assign st_mask_n_o = st_misaligned_o ? MASK_NONE : ~lane_hit;

  always_comb begin
    ld_byte = ld_raw_i[7:0];
    case (ld_addr_i)
      2'd0:    ld_byte = ld_raw_i[7:0];
      2'd1:    ld_byte = ld_raw_i[15:8];
      2'd2:    ld_byte = ld_raw_i[23:16];
      default: ld_byte = ld_raw_i[31:24];
    endcase
  end

  assign ld_half = ld_addr_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];

  always_comb begin
    ld_data_o = '0;
    case (ld_size_i)
      SIZE_BYTE: ld_data_o = {{24{ld_signed_i & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_data_o = {{16{ld_signed_i & ld_half[15]}}, ld_half};
      SIZE_WORD: ld_data_o = ld_raw_i;
      default:   ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one synchronous single-port RAM between an instruction-fetch
//   port and a load/store data port. Each access takes three cycles:
//   IDLE (arbitrate) -> ACCESS (RAM address presented, ack high)
//   -> CAPTURE (RAM read data returned) -> IDLE (valid pulse).
//   Ties are broken round-robin; after reset the data port wins first.
//
//   Ports
//     clk, reset          : clock, synchronous active-high reset
//     fetch_req/addr      : word fetch request (addr[1:0] don't-care)
//     fetch_ack/valid     : grant pulse (ACCESS), completion pulse
//     fetch_data          : fetched word, held until next fetch completion
//     data_req/we/size/signed/addr/wdata : load/store request
//     data_ack/valid/error: grant pulse, completion pulse, bad-access flag
//     data_rdata          : extended load data, held until next completion
//     ram_address/data_in/write_mask/write_enable : registered RAM controls
//                           (write_mask is active-low per byte lane)
//     ram_data_out        : RAM read data, one cycle after the address
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_ack,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_data,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic                  data_signed,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_ack,
  output logic                  data_valid,
  output logic                  data_error,
  output logic [31:0]           data_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_data_in,
  output logic [3:0]            ram_write_mask,
  output logic                  ram_write_enable,
  input  logic [31:0]           ram_data_out
);

  // FSM and arbitration state
  state_e state_q, state_d;
  logic   last_fetch_q, last_fetch_d;
  logic   grant_fetch, grant_data;

  // Attributes of the transaction in flight, latched at grant
  logic       sel_data_q, sel_data_d;
  logic [1:0] size_q, size_d;
  logic [1:0] addr_lo_q, addr_lo_d;
  logic       signed_q, signed_d;
  logic       err_q, err_d;

  // Registered outputs
  logic                  fetch_ack_q, fetch_ack_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic [31:0]           fetch_data_q, fetch_data_d;
  logic                  data_ack_q, data_ack_d;
  logic                  data_valid_q, data_valid_d;
  logic                  data_error_q, data_error_d;
  logic [31:0]           data_rdata_q, data_rdata_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [31:0]           ram_data_in_q, ram_data_in_d;
  logic [3:0]            ram_write_mask_q, ram_write_mask_d;
  logic                  ram_write_enable_q, ram_write_enable_d;

  // Lane steering
  logic [31:0] st_wdata;
  logic [3:0]  st_mask_n;
  logic        st_misaligned;
  logic [31:0] ld_data;

  mem_align u_mem_align (
    .st_size_i       (data_size),
    .st_addr_i       (data_addr[1:0]),
    .st_wdata_i      (data_wdata),
    .st_wdata_o      (st_wdata),
    .st_mask_n_o     (st_mask_n),
    .st_misaligned_o (st_misaligned),
    .ld_size_i       (size_q),
    .ld_addr_i       (addr_lo_q),
    .ld_signed_i     (signed_q),
    .ld_raw_i        (ram_data_out),
    .ld_data_o       (ld_data)
  );

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_fetch_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and arbitration
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_fetch_d = last_fetch_q;
    grant_fetch  = 1'b0;
    grant_data   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // On a tie, whichever port did not win last time goes now.
        grant_data  = data_req & (~fetch_req | last_fetch_q);
        grant_fetch = fetch_req & ~grant_data;
        if (grant_data || grant_fetch) begin
          state_d      = ST_ACCESS;
          last_fetch_d = grant_fetch;
        end
      end
      ST_ACCESS:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output / datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    // Pulses and RAM strobes default to inactive; data/address hold.
    fetch_ack_d        = 1'b0;
    fetch_valid_d      = 1'b0;
    fetch_data_d       = fetch_data_q;
    data_ack_d         = 1'b0;
    data_valid_d       = 1'b0;
    data_error_d       = 1'b0;
    data_rdata_d       = data_rdata_q;
    ram_address_d      = ram_address_q;
    ram_data_in_d      = ram_data_in_q;
    ram_write_mask_d   = MASK_NONE;
    ram_write_enable_d = 1'b0;
    sel_data_d         = sel_data_q;
    size_d             = size_q;
    addr_lo_d          = addr_lo_q;
    signed_d           = signed_q;
    err_d              = err_q;

    if (grant_data) begin
      data_ack_d    = 1'b1;
      ram_address_d = data_addr;
      ram_data_in_d = st_wdata;
      // A bad access still runs through the pipeline but never writes.
      if (data_we && !st_misaligned) begin
        ram_write_enable_d = 1'b1;
        ram_write_mask_d   = st_mask_n;
      end
      sel_data_d = 1'b1;
      size_d     = data_size;
      addr_lo_d  = data_addr[1:0];
      signed_d   = data_signed;
      err_d      = st_misaligned;
    end else if (grant_fetch) begin
      fetch_ack_d   = 1'b1;
      ram_address_d = fetch_addr;
      ram_data_in_d = '0;
      sel_data_d    = 1'b0;
    end

    // RAM read data is present during CAPTURE; register it on the way out.
    if (state_q == ST_CAPTURE) begin
      if (sel_data_q) begin
        data_valid_d = 1'b1;
        data_error_d = err_q;
        data_rdata_d = err_q ? 32'h0 : ld_data;
      end else begin
        fetch_valid_d = 1'b1;
        fetch_data_d  = ram_data_out;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_ack_q        <= 1'b0;
      fetch_valid_q      <= 1'b0;
      fetch_data_q       <= '0;
      data_ack_q         <= 1'b0;
      data_valid_q       <= 1'b0;
      data_error_q       <= 1'b0;
      data_rdata_q       <= '0;
      ram_address_q      <= '0;
      ram_data_in_q      <= '0;
      ram_write_mask_q   <= MASK_NONE;
      ram_write_enable_q <= 1'b0;
      sel_data_q         <= 1'b0;
      size_q             <= SIZE_BYTE;
      addr_lo_q          <= 2'd0;
      signed_q           <= 1'b0;
      err_q              <= 1'b0;
    end else begin
      fetch_ack_q        <= fetch_ack_d;
      fetch_valid_q      <= fetch_valid_d;
      fetch_data_q       <= fetch_data_d;
      data_ack_q         <= data_ack_d;
      data_valid_q       <= data_valid_d;
      data_error_q       <= data_error_d;
      data_rdata_q       <= data_rdata_d;
      ram_address_q      <= ram_address_d;
      ram_data_in_q      <= ram_data_in_d;
      ram_write_mask_q   <= ram_write_mask_d;
      ram_write_enable_q <= ram_write_enable_d;
      sel_data_q         <= sel_data_d;
      size_q             <= size_d;
      addr_lo_q          <= addr_lo_d;
      signed_q           <= signed_d;
      err_q              <= err_d;
    end
  end

  assign fetch_ack        = fetch_ack_q;
  assign fetch_valid      = fetch_valid_q;
  assign fetch_data       = fetch_data_q;
  assign data_ack         = data_ack_q;
  assign data_valid       = data_valid_q;
  assign data_error       = data_error_q;
  assign data_rdata       = data_rdata_q;
  assign ram_address      = ram_address_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_write_mask   = ram_write_mask_q;
  assign ram_write_enable = ram_write_enable_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ack, fetch_valid;
  logic [31:0]   fetch_data;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [1:0]    data_size = 2'd0;
  logic          data_signed = 1'b0;
  logic [AW-1:0] data_addr = '0;
  logic [31:0]   data_wdata = '0;
  logic          data_ack, data_valid, data_error;
  logic [31:0]   data_rdata;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data_in;
  logic [3:0]    ram_write_mask;
  logic          ram_write_enable;
  logic [31:0]   ram_data_out = '0;

  logic [7:0] mem [0:1023] = '{default: 8'h11};

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_ack        (fetch_ack),
    .fetch_valid      (fetch_valid),
    .fetch_data       (fetch_data),
    .data_req         (data_req),
    .data_we          (data_we),
    .data_size        (data_size),
    .data_signed      (data_signed),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_ack         (data_ack),
    .data_valid       (data_valid),
    .data_error       (data_error),
    .data_rdata       (data_rdata),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_write_mask   (ram_write_mask),
    .ram_write_enable (ram_write_enable),
    .ram_data_out     (ram_data_out)
  );

  // Behavioural synchronous RAM: masked byte writes, registered read.
  always @(posedge clk) begin
    if (ram_write_enable) begin
      for (int i = 0; i < 4; i++) begin
        if (!ram_write_mask[i])
          mem[{ram_address[9:2], 2'(i)}] <= ram_data_in[8*i +: 8];
      end
    end
    ram_data_out <= {mem[{ram_address[9:2], 2'd3}], mem[{ram_address[9:2], 2'd2}],
                     mem[{ram_address[9:2], 2'd1}], mem[{ram_address[9:2], 2'd0}]};
  end

  // Drive one data-port transaction starting at a negedge; report latencies
  // (-1 on timeout) and what was seen on the RAM side during ACCESS.
  task automatic data_xfer(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [AW-1:0] addr, input logic [31:0] wd,
                           output int ack_lat, output int val_lat,
                           output logic [3:0] mask, output logic wen,
                           output logic [AW-1:0] raddr, output logic [31:0] din,
                           output logic [31:0] rdata, output logic err,
                           output logic we_any);
    data_we = we; data_size = size; data_signed = sgn; data_addr = addr; data_wdata = wd;
    data_req = 1'b1;
    ack_lat = -1; val_lat = -1; we_any = 1'b0;
    mask = 4'hx; wen = 1'bx; raddr = 'x; din = 'x; rdata = 'x; err = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we_any |= ram_write_enable;
      if (data_ack) begin ack_lat = i; break; end
    end
    mask = ram_write_mask; wen = ram_write_enable; raddr = ram_address; din = ram_data_in;
    data_req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      we_any |= ram_write_enable;
      if (data_valid) begin val_lat = i; break; end
    end
    rdata = data_rdata; err = data_error;
    $display("data  we=%0d size=%0d sgn=%0d addr=%03h wdata=%08h | mask=%b din=%08h rdata=%08h err=%0d ack_lat=%0d val_lat=%0d",
             we, size, sgn, addr, wd, mask, din, rdata, err, ack_lat, val_lat);
  endtask

  task automatic fetch_xfer(input logic [AW-1:0] addr, output int ack_lat, output int val_lat,
                            output logic wen, output logic [AW-1:0] raddr,
                            output logic [31:0] fdata);
    fetch_addr = addr;
    fetch_req = 1'b1;
    ack_lat = -1; val_lat = -1; wen = 1'bx; raddr = 'x; fdata = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fetch_ack) begin ack_lat = i; break; end
    end
    wen = ram_write_enable; raddr = ram_address;
    fetch_req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (fetch_valid) begin val_lat = i; break; end
    end
    fdata = fetch_data;
    $display("fetch addr=%03h | raddr=%03h data=%08h ack_lat=%0d val_lat=%0d",
             addr, raddr, fdata, ack_lat, val_lat);
  endtask

  task automatic test_reset();
    // Requests held high during reset must not be acknowledged.
    fetch_req = 1'b1; data_req = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({fetch_ack, data_ack, fetch_valid, data_valid, data_error, ram_write_enable} !== 6'b0)
      $display("FAIL reset_strobes: got %b expected 000000",
               {fetch_ack, data_ack, fetch_valid, data_valid, data_error, ram_write_enable});
    else pass_cnt++;
    total_cnt++;
    if (ram_write_mask !== 4'hF) $display("FAIL reset_mask: got %b expected 1111", ram_write_mask);
    else pass_cnt++;
    total_cnt++;
    if ({ram_address, ram_data_in, fetch_data, data_rdata} !== '0)
      $display("FAIL reset_regs: got addr=%03h din=%08h fd=%08h rd=%08h expected all zero",
               ram_address, ram_data_in, fetch_data, data_rdata);
    else pass_cnt++;
    total_cnt++;
    if (dut.state_q !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE);
    else pass_cnt++;
    fetch_req = 1'b0; data_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_tie();
    int cyc[3];
    logic [2:0] is_data;
    int n;
    cyc = '{-1, -1, -1}; is_data = 3'b000; n = 0;
    data_we = 1'b0; data_size = SIZE_WORD; data_signed = 1'b0; data_addr = 10'h100;
    fetch_addr = 10'h104;
    fetch_req = 1'b1; data_req = 1'b1;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (data_ack || fetch_ack) begin
        cyc[n] = c; is_data[n] = data_ack; n++;
        $display("tie   grant %0d to %s at cycle %0d", n, data_ack ? "data" : "fetch", c);
      end
    end
    fetch_req = 1'b0; data_req = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (n !== 3) $display("FAIL tie_grant_count: got %0d expected 3", n);
    else pass_cnt++;
    total_cnt++;
    if (is_data !== 3'b101) $display("FAIL tie_order: got %b expected 101 (data,fetch,data)", is_data);
    else pass_cnt++;
    total_cnt++;
    if (cyc[1] - cyc[0] !== 3) $display("FAIL tie_spacing1: got %0d expected 3", cyc[1] - cyc[0]);
    else pass_cnt++;
    total_cnt++;
    if (cyc[2] - cyc[1] !== 3) $display("FAIL tie_spacing2: got %0d expected 3", cyc[2] - cyc[1]);
    else pass_cnt++;
  endtask

  task automatic test_sb();
    int al, vl; logic [3:0] m; logic w, e, wa; logic [AW-1:0] ra; logic [31:0] di, rd;
    data_xfer(1'b1, SIZE_BYTE, 1'b0, 10'h013, 32'h123456A5, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (m !== 4'b0111 || w !== 1'b1) $display("FAIL sb_mask: got mask=%b we=%b expected mask=0111 we=1", m, w);
    else pass_cnt++;
    total_cnt++;
    if (di !== 32'hA5A5A5A5 || ra !== 10'h013)
      $display("FAIL sb_lanes: got din=%08h addr=%03h expected din=a5a5a5a5 addr=013", di, ra);
    else pass_cnt++;
    total_cnt++;
    if (al !== 0 || vl !== 2 || e !== 1'b0)
      $display("FAIL sb_timing: got ack_lat=%0d val_lat=%0d err=%b expected 0 2 0", al, vl, e);
    else pass_cnt++;
    data_xfer(1'b0, SIZE_BYTE, 1'b0, 10'h013, 32'h0, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (rd !== 32'h000000A5) $display("FAIL lbu_rdata: got %08h expected 000000a5", rd);
    else pass_cnt++;
    total_cnt++;
    if (wa !== 1'b0 || m !== 4'hF) $display("FAIL lbu_no_write: got we_any=%b mask=%b expected 0 1111", wa, m);
    else pass_cnt++;
    data_xfer(1'b0, SIZE_BYTE, 1'b1, 10'h013, 32'h0, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (rd !== 32'hFFFFFFA5) $display("FAIL lb_rdata: got %08h expected ffffffa5", rd);
    else pass_cnt++;
    data_xfer(1'b0, SIZE_WORD, 1'b0, 10'h010, 32'h0, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (rd !== 32'hA5111111) $display("FAIL sb_neighbours: got %08h expected a5111111", rd);
    else pass_cnt++;
  endtask

  task automatic test_sh();
    int al, vl; logic [3:0] m; logic w, e, wa; logic [AW-1:0] ra; logic [31:0] di, rd;
    data_xfer(1'b1, SIZE_HALF, 1'b0, 10'h022, 32'hCAFE8001, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (m !== 4'b0011 || w !== 1'b1) $display("FAIL sh_mask: got mask=%b we=%b expected mask=0011 we=1", m, w);
    else pass_cnt++;
    total_cnt++;
    if (di !== 32'h80018001) $display("FAIL sh_lanes: got din=%08h expected 80018001", di);
    else pass_cnt++;
    data_xfer(1'b0, SIZE_HALF, 1'b1, 10'h022, 32'h0, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (rd !== 32'hFFFF8001) $display("FAIL lh_rdata: got %08h expected ffff8001", rd);
    else pass_cnt++;
    data_xfer(1'b0, SIZE_HALF, 1'b0, 10'h020, 32'h0, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (rd !== 32'h00001111) $display("FAIL sh_low_half_unchanged: got %08h expected 00001111", rd);
    else pass_cnt++;
  endtask

  task automatic test_fetch_latency();
    int al, vl; logic [3:0] m; logic w, e, wa; logic [AW-1:0] ra; logic [31:0] di, rd, fd;
    data_xfer(1'b1, SIZE_WORD, 1'b0, 10'h100, 32'hDEADBEEF, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (m !== 4'b0000 || di !== 32'hDEADBEEF)
      $display("FAIL sw_mask: got mask=%b din=%08h expected 0000 deadbeef", m, di);
    else pass_cnt++;
    fetch_xfer(10'h100, al, vl, w, ra, fd);
    total_cnt++;
    if (fd !== 32'hDEADBEEF) $display("FAIL fetch_data: got %08h expected deadbeef", fd);
    else pass_cnt++;
    total_cnt++;
    if (al !== 0 || vl !== 2) $display("FAIL fetch_latency: got ack_lat=%0d val_lat=%0d expected 0 2", al, vl);
    else pass_cnt++;
    total_cnt++;
    if (w !== 1'b0 || ra !== 10'h100) $display("FAIL fetch_ram_ctl: got we=%b addr=%03h expected 0 100", w, ra);
    else pass_cnt++;
    fetch_xfer(10'h102, al, vl, w, ra, fd);
    total_cnt++;
    if (fd !== 32'hDEADBEEF || ra !== 10'h102)
      $display("FAIL fetch_low_bits: got data=%08h addr=%03h expected deadbeef 102", fd, ra);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    int al, vl; logic [3:0] m; logic w, e, wa; logic [AW-1:0] ra; logic [31:0] di, rd;
    data_xfer(1'b0, SIZE_WORD, 1'b0, 10'h006, 32'h0, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (al !== 0 || vl !== 2) $display("FAIL lw_mis_timing: got ack_lat=%0d val_lat=%0d expected 0 2", al, vl);
    else pass_cnt++;
    total_cnt++;
    if (e !== 1'b1 || rd !== 32'h0) $display("FAIL lw_mis_result: got err=%b rdata=%08h expected 1 00000000", e, rd);
    else pass_cnt++;
    total_cnt++;
    if (wa !== 1'b0) $display("FAIL lw_mis_we: got we_any=%b expected 0", wa);
    else pass_cnt++;
    data_xfer(1'b1, SIZE_HALF, 1'b0, 10'h023, 32'h00001234, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (wa !== 1'b0 || m !== 4'hF || e !== 1'b1)
      $display("FAIL sh_mis: got we_any=%b mask=%b err=%b expected 0 1111 1", wa, m, e);
    else pass_cnt++;
    data_xfer(1'b0, SIZE_WORD, 1'b0, 10'h020, 32'h0, al, vl, m, w, ra, di, rd, e, wa);
    total_cnt++;
    if (rd !== 32'h80011111) $display("FAIL sh_mis_no_commit: got %08h expected 80011111", rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int al, vl; logic w; logic [AW-1:0] ra; logic [31:0] fd;
    logic ack_seen, valid_seen;
    data_we = 1'b0; data_size = SIZE_WORD; data_signed = 1'b0; data_addr = 10'h100;
    data_req = 1'b1;
    ack_seen = 1'b0; valid_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_ack) begin ack_seen = 1'b1; break; end
    end
    data_req = 1'b0;
    total_cnt++;
    if (ack_seen !== 1'b1) $display("FAIL rstmid_ack: got %b expected 1", ack_seen);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (dut.state_q !== ST_CAPTURE) $display("FAIL rstmid_in_capture: got %0d expected %0d", dut.state_q, ST_CAPTURE);
    else pass_cnt++;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      valid_seen |= data_valid;
    end
    total_cnt++;
    if (dut.state_q !== ST_IDLE) $display("FAIL rstmid_state: got %0d expected %0d", dut.state_q, ST_IDLE);
    else pass_cnt++;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      valid_seen |= data_valid;
    end
    total_cnt++;
    if (valid_seen !== 1'b0) $display("FAIL rstmid_no_valid: got %b expected 0", valid_seen);
    else pass_cnt++;
    $display("reset pulsed during CAPTURE");
    fetch_xfer(10'h100, al, vl, w, ra, fd);
    total_cnt++;
    if (fd !== 32'hDEADBEEF || al !== 0 || vl !== 2)
      $display("FAIL rstmid_fetch: got data=%08h ack_lat=%0d val_lat=%0d expected deadbeef 0 2", fd, al, vl);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_sb();
    test_sh();
    test_fetch_latency();
    test_misaligned();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by t=%0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
